// File: rtl/axil_ram_slave.sv
`timescale 1ns/1ps
// axil_ram_slave
// AXI4-Lite responder backed by a word-addressed RAM. Accepts AW and W
// independently (one outstanding write) and serves one outstanding read.
// Addresses are decoded relative to BASE_ADDR; RAM is not cleared by reset.
//
// Optional feature: define AXIL_RAM_SLVERR_EN to range-check addresses.
// Out-of-range writes are dropped with SLVERR, and out-of-range reads return
// zero with SLVERR. When it is undefined, addresses alias through the index
// bits and every response is OKAY.
//
// Ports
//   ACLK, ARESETN          clock, synchronous active-low reset
//   S_AW*                  write address channel (S_AWPROT ignored)
//   S_W*                   write data channel, S_WSTRB = byte-lane enables
//   S_B*                   write response channel
//   S_AR*                  read address channel (S_ARPROT ignored)
//   S_R*                   read data channel
//
// Write FSM
//   state    | meaning
//   W_IDLE   | nothing held
//   W_HALF   | either AW or W held, waiting for the other
//   W_COMMIT | both held; the RAM is written on the next edge
//   W_RESP   | S_BVALID high, waiting for S_BREADY
module axil_ram_slave #(
    parameter int                      AXI_DWIDTH  = 32,
    parameter int                      AXI_AWIDTH  = 32,
    parameter logic [AXI_AWIDTH-1:0]   BASE_ADDR   = '0,
    parameter int                      DEPTH_WORDS = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [AXI_AWIDTH-1:0]   S_AWADDR,
    input  logic [2:0]              S_AWPROT,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   S_WDATA,
    input  logic [3:0]              S_WSTRB,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [AXI_AWIDTH-1:0]   S_ARADDR,
    input  logic [2:0]              S_ARPROT,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [AXI_DWIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RVALID,
    input  logic                    S_RREADY
);

    localparam int         IW     = $clog2(DEPTH_WORDS);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HALF, W_COMMIT, W_RESP} wstate_t;

    wstate_t                 wstate;
    logic                    rdy_en;
    logic                    aw_full, w_full;
    logic [IW-1:0]           aw_idx;
    logic                    aw_err;
    logic [AXI_DWIDTH-1:0]   w_data;
    logic [3:0]              w_strb;
    logic [AXI_DWIDTH-1:0]   mem [DEPTH_WORDS];

    // One extra bit so an address below BASE_ADDR wraps to a huge offset
    // and fails the range compare without a second comparison.
    logic [AXI_AWIDTH:0] aw_off, ar_off;
    assign aw_off = {1'b0, S_AWADDR} - {1'b0, BASE_ADDR};
    assign ar_off = {1'b0, S_ARADDR} - {1'b0, BASE_ADDR};

`ifdef AXIL_RAM_SLVERR_EN
    localparam logic [AXI_AWIDTH:0] SPAN = (AXI_AWIDTH+1)'(DEPTH_WORDS) << 2;
    logic aw_in_range, ar_in_range;
    assign aw_in_range = aw_off < SPAN;
    assign ar_in_range = ar_off < SPAN;
`endif

    logic unused_bits;
    assign unused_bits = ^{S_AWPROT, S_ARPROT, aw_off[1:0], ar_off[1:0],
                           aw_off[AXI_AWIDTH:IW+2], ar_off[AXI_AWIDTH:IW+2]};

    assign S_AWREADY = rdy_en & ~aw_full & ~S_BVALID;
    assign S_WREADY  = rdy_en & ~w_full  & ~S_BVALID;
    assign S_ARREADY = rdy_en & ~S_RVALID;

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = S_AWVALID & S_AWREADY;
    assign w_hs  = S_WVALID  & S_WREADY;
    assign ar_hs = S_ARVALID & S_ARREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rdy_en   <= 1'b0;
            wstate   <= W_IDLE;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx   <= '0;
            aw_err   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            S_BVALID <= 1'b0;
            S_BRESP  <= OKAY;
        end else begin
            rdy_en <= 1'b1;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= aw_off[IW+1:2];
`ifdef AXIL_RAM_SLVERR_EN
                aw_err  <= ~aw_in_range;
`else
                aw_err  <= 1'b0;
`endif
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_WDATA;
                w_strb <= S_WSTRB;
            end
            case (wstate)
                W_IDLE, W_HALF: begin
                    if ((aw_full | aw_hs) & (w_full | w_hs))
                        wstate <= W_COMMIT;
                    else if (aw_full | aw_hs | w_full | w_hs)
                        wstate <= W_HALF;
                    else
                        wstate <= W_IDLE;
                end
                W_COMMIT: begin
                    aw_full  <= 1'b0;
                    w_full   <= 1'b0;
                    S_BVALID <= 1'b1;
                    S_BRESP  <= aw_err ? SLVERR : OKAY;
                    wstate   <= W_RESP;
                end
                W_RESP: begin
                    if (S_BREADY) begin
                        S_BVALID <= 1'b0;
                        wstate   <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // RAM has no reset; a commit is suppressed while ARESETN is low so an
    // uncommitted write is discarded.
    always_ff @(posedge ACLK) begin
        if (ARESETN && wstate == W_COMMIT && !aw_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i])
                    mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    // Reads sample the RAM before a same-edge commit lands (read-before-write).
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            S_RVALID <= 1'b0;
            S_RDATA  <= '0;
            S_RRESP  <= OKAY;
        end else if (ar_hs) begin
            S_RVALID <= 1'b1;
`ifdef AXIL_RAM_SLVERR_EN
            if (ar_in_range) begin
                S_RDATA <= mem[ar_off[IW+1:2]];
                S_RRESP <= OKAY;
            end else begin
                S_RDATA <= '0;
                S_RRESP <= SLVERR;
            end
`else
            S_RDATA <= mem[ar_off[IW+1:2]];
            S_RRESP <= OKAY;
`endif
        end else if (S_RVALID && S_RREADY) begin
            S_RVALID <= 1'b0;
        end
    end

endmodule
